// File: rtl/stream_demux_1x4_if.sv
// Handshake and data bundle for the 1-to-4 stream demultiplexer.
// The master side drives beats and per-channel ready; the slave side is the demux.
interface stream_demux_1x4_if #(
  parameter int in_width = 8
);
  logic [in_width-1:0] input0;
  logic                in_valid;
  logic [1:0]          select;
  logic                in_ready;
  logic [in_width-1:0] output0;
  logic [in_width-1:0] output1;
  logic [in_width-1:0] output2;
  logic [in_width-1:0] output3;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [7:0]          count0;
  logic [7:0]          count1;
  logic [7:0]          count2;
  logic [7:0]          count3;

  modport slave (
    input  input0, in_valid, select, out_ready,
    output in_ready, output0, output1, output2, output3, out_valid,
    output count0, count1, count2, count3
  );

  modport master (
    output input0, in_valid, select, out_ready,
    input  in_ready, output0, output1, output2, output3, out_valid,
    input  count0, count1, count2, count3
  );
endinterface

// File: rtl/stream_demux_1x4.sv
// Routes each accepted beat to one of four single-entry output registers chosen by select.
// Latency: 1 cycle from accept to out_valid; each channel sustains 1 beat/cycle.
// Backpressure: in_ready drops only when the selected channel is full and not draining.
module stream_demux_1x4 #(
  parameter int in_width = 8
) (
  input logic               clk,
  input logic               rst_n,
  stream_demux_1x4_if.slave bus
);

  logic [in_width-1:0] data_q [4];
  logic [7:0]          cnt_q  [4];
  logic [3:0]          vld_q;
  logic [3:0]          load;
  logic [3:0]          deliver;
  logic                in_ready_w;
  logic                accept;

  // Only the selected channel gates acceptance; other channels never block.
  assign in_ready_w = !vld_q[bus.select] || bus.out_ready[bus.select];
  assign accept     = bus.in_valid && in_ready_w;
  assign deliver    = vld_q & bus.out_ready;

  for (genvar k = 0; k < 4; k++) begin : g_load
    assign load[k] = accept && (bus.select == 2'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // A load wins over a same-edge drain so the channel stays full.
        if (load[k]) begin
          data_q[k] <= bus.input0;
          vld_q[k]  <= 1'b1;
        end else if (deliver[k]) begin
          vld_q[k]  <= 1'b0;
        end
        if (deliver[k]) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = vld_q;
  assign bus.output0   = data_q[0];
  assign bus.output1   = data_q[1];
  assign bus.output2   = data_q[2];
  assign bus.output3   = data_q[3];
  assign bus.count0    = cnt_q[0];
  assign bus.count1    = cnt_q[1];
  assign bus.count2    = cnt_q[2];
  assign bus.count3    = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Randomized and directed stimulus for stream_demux_1x4, checked by a per-channel
// scoreboard of undelivered beats, held values and delivery counts.
module tb_stream_demux_1x4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_1x4_if #(.in_width(W)) bus ();

  stream_demux_1x4 #(.in_width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: pending beats per channel, last loaded value, delivery totals.
  logic [W-1:0] q [4][$];
  logic [W-1:0] held [4];
  int           cnt_m [4];
  bit           seen_rst = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  bit           pend_v = 1'b0;
  int           pend_ch = 0;
  logic [W-1:0] pend_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] out_k(input int k);
    case (k)
      0: return bus.output0;
      1: return bus.output1;
      2: return bus.output2;
      default: return bus.output3;
    endcase
  endfunction

  function automatic logic [7:0] count_k(input int k);
    case (k)
      0: return bus.count0;
      1: return bus.count1;
      2: return bus.count2;
      default: return bus.count3;
    endcase
  endfunction

  // Drives one cycle of inputs; the model records the beat as issued when the
  // channel it targets is empty or draining, and enqueues it at the accepting edge.
  task automatic step(input bit v, input int sel, input logic [W-1:0] d,
                      input logic [3:0] ordy, input bit rst);
    @(posedge clk);
    if (pend_v) begin
      q[pend_ch].push_back(pend_d);
      held[pend_ch] = pend_d;
    end
    pend_v = 1'b0;
    #1;
    rst_n         = rst;
    bus.in_valid  = v;
    bus.select    = 2'(sel);
    bus.input0    = d;
    bus.out_ready = ordy;
    if (rst && v && (q[sel].size() == 0 || ordy[sel])) begin
      pend_v  = 1'b1;
      pend_ch = sel;
      pend_d  = d;
    end
  endtask

  // Monitor: compares DUT state to the model mid-cycle, then retires deliveries.
  initial begin
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        chk("in_ready", 32'(bus.in_ready),
            32'(q[bus.select].size() == 0 || bus.out_ready[bus.select]));
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(q[k].size() != 0));
          chk($sformatf("output%0d_held", k), 32'(out_k(k)), 32'(held[k]));
          chk($sformatf("count%0d", k), 32'(count_k(k)), 32'(cnt_m[k] % 256));
          if (rst_n && q[k].size() != 0 && bus.out_ready[k]) begin
            chk($sformatf("deliver%0d_data", k), 32'(out_k(k)), 32'(q[k][0]));
            void'(q[k].pop_front());
            cnt_m[k]++;
          end
        end
      end
      if (!rst_n) begin
        seen_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
          q[k].delete();
          held[k]  = '0;
          cnt_m[k] = 0;
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.select    = 2'd0;
    bus.input0    = '0;
    bus.out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      held[k]  = '0;
      cnt_m[k] = 0;
    end

    step(0, 0, 8'h00, 4'b0000, 0);
    step(0, 0, 8'h00, 4'b0000, 0);
    step(0, 1, 8'h00, 4'b0000, 1);
    step(0, 3, 8'h00, 4'b0000, 1);

    // Pass-through on channel 2.
    step(1, 2, 8'hA5, 4'b0100, 1);
    step(0, 2, 8'h00, 4'b0100, 1);
    step(0, 0, 8'h00, 4'b0000, 1);

    // Stall on channel 1 while channel 3 still accepts.
    step(1, 1, 8'h11, 4'b0000, 1);
    step(1, 1, 8'h22, 4'b0000, 1);
    step(1, 3, 8'h33, 4'b0000, 1);
    step(0, 2, 8'h00, 4'b0000, 1);
    step(0, 0, 8'h00, 4'b1010, 1);
    step(0, 0, 8'h00, 4'b0000, 1);

    // Back-to-back beats 1..5 on channel 0.
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 4'b0001, 1);
    step(0, 1, 8'h00, 4'b0001, 1);
    step(0, 0, 8'h00, 4'b0001, 1);

    // Drain-and-load on channel 2.
    step(1, 2, 8'h7E, 4'b0000, 1);
    step(1, 2, 8'h3C, 4'b0100, 1);
    step(0, 2, 8'h00, 4'b0000, 1);
    step(0, 2, 8'h00, 4'b0100, 1);

    // Reset mid-operation with channels 0,1,3 full and an accept on the same edge.
    step(1, 0, 8'hC0, 4'b0000, 1);
    step(1, 1, 8'hC1, 4'b0000, 1);
    step(1, 3, 8'hC3, 4'b0000, 1);
    step(1, 2, 8'hC2, 4'b1111, 0);
    step(0, 0, 8'h00, 4'b0000, 1);
    step(0, 0, 8'h00, 4'b0000, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = 4'b0000;
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
           r, $urandom_range(0, 299) != 0);
    end

    // Counter wrap: exactly 256 deliveries on channel 3 after a clean reset.
    step(0, 0, 8'h00, 4'b0000, 0);
    for (int i = 0; i < 256; i++) step(1, 3, 8'(i), 4'b1000, 1);
    step(0, 3, 8'h00, 4'b1000, 1);
    step(0, 0, 8'h00, 4'b0000, 1);
    @(negedge clk);
    chk("wrap_count3", 32'(bus.count3), 32'd0);
    chk("wrap_count0", 32'(bus.count0), 32'd0);
    chk("wrap_count1", 32'(bus.count1), 32'd0);
    chk("wrap_count2", 32'(bus.count2), 32'd0);
    chk("wrap_total3", 32'(cnt_m[3]), 32'd256);

    step(0, 0, 8'h00, 4'b0000, 1);
    step(0, 0, 8'h00, 4'b0000, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux_1x4.md
STREAM_DEMUX_1X4 -- requirements
Module: stream_demux_1x4

Interface
REQ-001 The block SHALL have parameter in_width, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous and active-low.
REQ-004 The block SHALL have port input0, input, in_width bits, the upstream payload.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning input0 and select are valid this cycle.
REQ-006 The block SHALL have port select, input, 2 bits, the destination channel (0..3) for input0.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the beat this cycle.
REQ-008 The block SHALL have ports output0..output3, output, in_width bits each, the per-channel held payloads.
REQ-009 The block SHALL have port out_valid, output, 4 bits, where bit k means outputk holds an undelivered beat.
REQ-010 The block SHALL have port out_ready, input, 4 bits, where bit k means the channel k consumer takes the beat.
REQ-011 The block SHALL have ports count0..count3, output, 8 bits each, giving the beats delivered per channel.

Function
REQ-012 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 A delivery on channel k SHALL occur on a rising edge where out_valid[k]=1 and out_ready[k]=1.
REQ-014 in_ready SHALL be combinational: !out_valid[select] | out_ready[select], independent of in_valid and of unselected channels.
REQ-015 On an accept, outputk (k=select) SHALL load input0 and out_valid[k] SHALL be 1 the next cycle; latency is 1 cycle.
REQ-016 A delivery on channel k without an accept to k SHALL clear out_valid[k] next cycle; outputk holds its last value.
REQ-017 A delivery and an accept on the same channel in the same edge SHALL load the new data with out_valid[k] staying 1, sustaining 1 beat/cycle.
REQ-018 While out_valid[k]=1 and out_ready[k]=0, outputk and out_valid[k] SHALL remain stable.
REQ-019 Channels SHALL be independent: a stalled channel SHALL NOT block accepts to other channels, nor deliveries on them.
REQ-020 Each countk SHALL increment by 1 per delivery on channel k and wrap 255 -> 0 without a flag.
REQ-021 A change of select while in_valid=0 SHALL have no effect on state.
REQ-022 Unselected channels' data SHALL never change due to an accept.

Reset
REQ-023 While rst_n=0 at a rising edge, out_valid SHALL become 4'b0000, output0..3 all zeros, and count0..3 zero.
REQ-024 Reset SHALL dominate same-edge accepts and deliveries; in-flight beats are discarded, and in_ready evaluates to 1 after reset.
REQ-025 Before the first clock edge with rst_n=0, outputs SHALL be treated as undefined.

Verification
REQ-026 Pass-through: in_valid=1, select=2, input0=8'hA5, out_ready=4'b0100 -> in_ready=1, next cycle output2=8'hA5, out_valid=4'b0100, count2 then increments to 1.
REQ-027 Stall/independence: out_ready=0, accept 8'h11 to ch1 -> out_valid[1]=1; a second beat to ch1 sees in_ready=0, output1 holds 8'h11; a beat to ch3 is accepted the same cycle.
REQ-028 Back-to-back: out_ready[0]=1, 5 consecutive beats 1..5 to ch0 -> in_ready stays 1, output0 shows 1..5 on successive cycles, and count0=5.
REQ-029 Wrap: 256 deliveries on ch3 -> count3 reads 0 and the other counts remain 0.
REQ-030 Reset mid-operation: with out_valid=4'b1011 and counts nonzero, assert rst_n=0 for one edge alongside an accept -> all out_valid, outputs, and counts 0; the accepted beat is lost.
REQ-031 Drain-and-load: out_valid[2]=1, out_ready[2]=1, and a simultaneous accept of 8'h3C to ch2 -> next cycle out_valid[2]=1, output2=8'h3C, count2 +1.
